// File: rtl/rx_downmixer.sv
// rtl/rx_downmixer.sv - real ADC to baseband I/Q CORDIC downmixer with integrate-and-dump decimator
// Optional macro RX_GAIN_COMP_EN: scales the mixer output by ~1/K at the cost of one pipeline register.
module rx_downmixer #(
    parameter int IW      = 16,
    parameter int OW      = 16,
    parameter int WW      = 20,
    parameter int NSTAGES = 16,
    parameter int PW_I    = 19,
    parameter int PW      = 23,
    parameter int DEC     = 8
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic [PW_I-1:0]      phase_input,
    input  logic signed [IW-1:0] adc_in,
    input  logic                 in_valid,
    output logic signed [OW-1:0] rx_i,
    output logic signed [OW-1:0] rx_q,
    output logic                 ce_down,
    output logic signed [OW-1:0] mix_i,
    output logic signed [OW-1:0] mix_q,
    output logic                 mix_valid
);
    // Two guard bits above WW keep K*full-scale inside the rotation datapath.
    localparam int XW = WW + 2;
    localparam int SH = WW - OW;
    localparam int LD = $clog2(DEC);
    localparam int AW = OW + LD;
    localparam logic signed [XW-1:0] OMAX = XW'(2 ** (OW - 1) - 1);
    localparam logic signed [XW-1:0] OMIN = -OMAX - XW'(1);

    function automatic logic [PW-1:0] atan_step(input int i);
        logic [32:0] a;
        case (i)
            0:  a = 33'd536870912;
            1:  a = 33'd316933406;
            2:  a = 33'd167458907;
            3:  a = 33'd85004756;
            4:  a = 33'd42667331;
            5:  a = 33'd21354465;
            6:  a = 33'd10679838;
            7:  a = 33'd5340245;
            8:  a = 33'd2670163;
            9:  a = 33'd1335087;
            10: a = 33'd667544;
            11: a = 33'd333772;
            12: a = 33'd166886;
            13: a = 33'd83443;
            14: a = 33'd41722;
            15: a = 33'd20861;
            default: a = 33'(32'd683565276 >> i);
        endcase
        a = a + (33'd1 << (31 - PW));
        atan_step = PW'(a >> (32 - PW));
    endfunction

    function automatic logic signed [OW-1:0] rnd_sat(input logic signed [XW-1:0] v);
        logic signed [XW-1:0] r;
        r = (v + XW'(2 ** (SH - 1))) >>> SH;
        if (r > OMAX)
            rnd_sat = OMAX[OW-1:0];
        else if (r < OMIN)
            rnd_sat = OMIN[OW-1:0];
        else
            rnd_sat = r[OW-1:0];
    endfunction

    logic [PW-1:0]         ph;
    logic signed [XW-1:0]  xin, x0, y0;
    logic signed [PW-1:0]  z0;
    logic signed [XW-1:0]  xs [0:NSTAGES];
    logic signed [XW-1:0]  ys [0:NSTAGES];
    logic signed [PW-1:0]  zs [0:NSTAGES-1];
    logic [NSTAGES:0]      vs;

    assign ph  = {phase_input, {(PW - PW_I){1'b0}}};
    assign xin = {{(XW - WW){adc_in[IW-1]}}, adc_in, {(WW - IW){1'b0}}};
    // Quadrant handled up front, residual rotation is -(phase mod 90 deg).
    assign z0  = -$signed({2'b00, ph[PW-3:0]});

    always_comb begin
        x0 = xin;
        y0 = '0;
        case (ph[PW-1:PW-2])
            2'd1: begin x0 = '0;   y0 = -xin; end
            2'd2: begin x0 = -xin; y0 = '0;   end
            2'd3: begin x0 = '0;   y0 = xin;  end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            vs <= '0;
            for (int s = 0; s <= NSTAGES; s++) begin
                xs[s] <= '0;
                ys[s] <= '0;
            end
            for (int s = 0; s < NSTAGES; s++)
                zs[s] <= '0;
        end else begin
            vs    <= {vs[NSTAGES-1:0], in_valid};
            xs[0] <= x0;
            ys[0] <= y0;
            zs[0] <= z0;
            for (int s = 0; s < NSTAGES; s++) begin
                if (zs[s][PW-1]) begin
                    xs[s+1] <= xs[s] + (ys[s] >>> s);
                    ys[s+1] <= ys[s] - (xs[s] >>> s);
                end else begin
                    xs[s+1] <= xs[s] - (ys[s] >>> s);
                    ys[s+1] <= ys[s] + (xs[s] >>> s);
                end
            end
            for (int s = 0; s < NSTAGES - 1; s++) begin
                if (zs[s][PW-1])
                    zs[s+1] <= zs[s] + $signed(atan_step(s));
                else
                    zs[s+1] <= zs[s] - $signed(atan_step(s));
            end
        end
    end

`ifdef RX_GAIN_COMP_EN
    localparam logic signed [15:0] GAIN_Q15 = 16'sd19898;
    localparam logic signed [OW+15:0] PMAX = (OW+16)'(2 ** (OW - 1) - 1);
    localparam logic signed [OW+15:0] PMIN = -PMAX - (OW+16)'(1);

    function automatic logic signed [OW-1:0] gain_comp(input logic signed [OW-1:0] v);
        logic signed [OW+15:0] p;
        p = (v * GAIN_Q15 + (OW+16)'(2 ** 14)) >>> 15;
        if (p > PMAX)
            gain_comp = PMAX[OW-1:0];
        else if (p < PMIN)
            gain_comp = PMIN[OW-1:0];
        else
            gain_comp = p[OW-1:0];
    endfunction

    logic signed [OW-1:0] raw_i, raw_q;
    logic                 raw_valid;

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            raw_i     <= '0;
            raw_q     <= '0;
            raw_valid <= 1'b0;
            mix_i     <= '0;
            mix_q     <= '0;
            mix_valid <= 1'b0;
        end else begin
            raw_i     <= rnd_sat(xs[NSTAGES]);
            raw_q     <= rnd_sat(ys[NSTAGES]);
            raw_valid <= vs[NSTAGES];
            mix_i     <= gain_comp(raw_i);
            mix_q     <= gain_comp(raw_q);
            mix_valid <= raw_valid;
        end
    end
`else
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            mix_i     <= '0;
            mix_q     <= '0;
            mix_valid <= 1'b0;
        end else begin
            mix_i     <= rnd_sat(xs[NSTAGES]);
            mix_q     <= rnd_sat(ys[NSTAGES]);
            mix_valid <= vs[NSTAGES];
        end
    end
`endif

    logic signed [AW-1:0] acc_i, acc_q, sum_i, sum_q;
    logic [LD-1:0]        cnt;

    assign sum_i = acc_i + AW'(mix_i);
    assign sum_q = acc_q + AW'(mix_q);

    // The DEC-th sample is folded into the dump so nothing is lost across the boundary.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            acc_i   <= '0;
            acc_q   <= '0;
            cnt     <= '0;
            rx_i    <= '0;
            rx_q    <= '0;
            ce_down <= 1'b0;
        end else begin
            ce_down <= 1'b0;
            if (mix_valid) begin
                if (cnt == LD'(DEC - 1)) begin
                    rx_i    <= OW'(sum_i >>> LD);
                    rx_q    <= OW'(sum_q >>> LD);
                    ce_down <= 1'b1;
                    acc_i   <= '0;
                    acc_q   <= '0;
                    cnt     <= '0;
                end else begin
                    acc_i <= sum_i;
                    acc_q <= sum_q;
                    cnt   <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_downmixer.sv
// tb/tb_rx_downmixer.sv - directed scoreboard bench for rx_downmixer
// Build with RX_GAIN_COMP_EN defined to check the gain-compensated variant.
module tb_rx_downmixer;
    localparam int DEC = 8;
    localparam real PI = 3.14159265358979;
`ifdef RX_GAIN_COMP_EN
    localparam int  LAT  = 19;
    localparam real GAIN = 1.646760258 * 19898.0 / 32768.0;
`else
    localparam int  LAT  = 18;
    localparam real GAIN = 1.646760258;
`endif

    logic               sys_clk = 1'b0;
    logic               rst;
    logic [18:0]        phase_input;
    logic signed [15:0] adc_in;
    logic               in_valid;
    logic signed [15:0] rx_i, rx_q, mix_i, mix_q;
    logic               ce_down, mix_valid;

    rx_downmixer dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .phase_input (phase_input),
        .adc_in      (adc_in),
        .in_valid    (in_valid),
        .rx_i        (rx_i),
        .rx_q        (rx_q),
        .ce_down     (ce_down),
        .mix_i       (mix_i),
        .mix_q       (mix_q),
        .mix_valid   (mix_valid)
    );

    always #5 sys_clk = ~sys_clk;

    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    mv_cnt = 0;
    logic  prev_ce = 1'b0;
    int    ce_times[$];
    int    sb_i[$], sb_q[$], sb_tol[$];
    string sb_tag[$];

    function automatic int rnd(input real x);
        rnd = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    task automatic check(input string tag, input int obs, input int exp, input int tol);
        int d;
        d = obs - exp;
        if (d < 0) d = -d;
        tests++;
        assert ((d <= tol) === 1'b1) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic push(input string tag, input int ei, input int eq, input int tol);
        sb_tag.push_back(tag);
        sb_i.push_back(ei);
        sb_q.push_back(eq);
        sb_tol.push_back(tol);
    endtask

    task automatic push_dc(input string tag, input int a, input int ph);
        real th;
        th = -2.0 * PI * ph / 524288.0;
        push(tag, rnd(GAIN * a * $cos(th)), rnd(GAIN * a * $sin(th)), 3);
    endtask

    task automatic step(input int a, input int ph, input logic v);
        @(posedge sys_clk);
        #2;
        adc_in      = 16'(a);
        phase_input = 19'(ph);
        in_valid    = v;
    endtask

    task automatic dc_block(input string tag, input int a, input int ph, input bit gap);
        for (int k = 0; k < DEC; k++) begin
            step(a, ph, 1'b1);
            if (gap) step(31000, 12345, 1'b0);
        end
        push_dc(tag, a, ph);
    endtask

    task automatic do_reset();
        @(posedge sys_clk);
        #2;
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge sys_clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && sb_i.size() > 0; k++) step(0, 0, 1'b0);
        check("sb_drained", sb_i.size(), 0, 0);
        repeat (3) step(0, 0, 1'b0);
    endtask

    always @(negedge sys_clk) begin
        cyc++;
        if (!rst) begin
            mv_cnt  = 0;
            prev_ce = 1'b0;
        end else begin
            if (ce_down) begin
                check("ce_not_back_to_back", int'(prev_ce), 0, 0);
                check("ce_after_dec_samples", mv_cnt, DEC, 0);
                mv_cnt = 0;
                ce_times.push_back(cyc);
                tests++;
                assert ((sb_i.size() > 0) === 1'b1) else begin
                    fails++;
                    $error("FAIL unexpected_ce: observed ce_down with rx_i=%0d, expected no strobe", rx_i);
                end
                if (sb_i.size() > 0) begin
                    check({sb_tag[0], "_i"}, int'(rx_i), sb_i[0], sb_tol[0]);
                    check({sb_tag[0], "_q"}, int'(rx_q), sb_q[0], sb_tol[0]);
                    void'(sb_tag.pop_front());
                    void'(sb_i.pop_front());
                    void'(sb_q.pop_front());
                    void'(sb_tol.pop_front());
                end
            end
            if (mix_valid) mv_cnt++;
            prev_ce = ce_down;
        end
    end

    initial begin
        #300000;
        fails++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0, lat;
        rst = 1'b0;
        adc_in = '0;
        phase_input = '0;
        in_valid = 1'b0;
        repeat (5) @(posedge sys_clk);
        #2;
        check("rst_rx_i", int'(rx_i), 0, 0);
        check("rst_rx_q", int'(rx_q), 0, 0);
        check("rst_ce_down", int'(ce_down), 0, 0);
        check("rst_mix_i", int'(mix_i), 0, 0);
        check("rst_mix_q", int'(mix_q), 0, 0);
        check("rst_mix_valid", int'(mix_valid), 0, 0);
        rst = 1'b1;

        n0 = ce_times.size();
        for (int b = 0; b < 3; b++) dc_block("dc_ph0", 10000, 0, 1'b0);
        drain();
        check("dc_ce_count", ce_times.size() - n0, 3, 0);
        if (ce_times.size() >= n0 + 2)
            check("dc_ce_period", ce_times[n0+1] - ce_times[n0], DEC, 0);

        dc_block("ph90", 10000, 131072, 1'b0);
        dc_block("ph90b", 10000, 131072, 1'b0);
        dc_block("ph180", 10000, 262144, 1'b0);
        dc_block("ph270", 10000, 393216, 1'b0);
        dc_block("ph45_neg", -10000, 65536, 1'b0);
        drain();

        do_reset();
        step(10000, 0, 1'b1);
        step(0, 0, 1'b0);
        lat = 1;
        while (mix_valid !== 1'b1 && lat < 60) begin
            @(posedge sys_clk);
            #2;
            lat++;
        end
        check("mix_latency", lat, LAT, 0);
        check("mix_i_pulse", int'(mix_i), rnd(GAIN * 10000.0), 3);
        check("mix_q_pulse", int'(mix_q), 0, 3);
        @(posedge sys_clk);
        #2;
        check("mix_valid_width", int'(mix_valid), 0, 0);

        do_reset();
        n0 = ce_times.size();
        dc_block("gap_ph0", 10000, 0, 1'b1);
        dc_block("gap_ph0b", 10000, 0, 1'b1);
        drain();
        check("gap_ce_count", ce_times.size() - n0, 2, 0);
        if (ce_times.size() >= n0 + 2)
            check("gap_ce_period", ce_times[n0+1] - ce_times[n0], 2 * DEC, 0);

        n0 = ce_times.size();
        repeat (5) step(10000, 0, 1'b1);
        repeat (25) step(0, 0, 1'b0);
        check("hold_rx_i", int'(rx_i), rnd(GAIN * 10000.0), 3);
        repeat (3) step(-20000, 65536, 1'b1);
        repeat (4) step(0, 0, 1'b0);
        @(posedge sys_clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_rx_i", int'(rx_i), 0, 0);
        check("midrst_mix_valid", int'(mix_valid), 0, 0);
        repeat (2) @(posedge sys_clk);
        #2;
        rst = 1'b1;
        repeat (30) step(0, 0, 1'b0);
        check("midrst_no_stale_ce", ce_times.size() - n0, 0, 0);
        dc_block("post_rst_ph180", 10000, 262144, 1'b0);
        drain();
        check("post_rst_ce_count", ce_times.size() - n0, 1, 0);

        do_reset();
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < DEC; k++) begin
                int n;
                n = b * DEC + k;
                step(rnd(20000.0 * $cos(2.0 * PI * n / 16.0)), (n * 32768) % 524288, 1'b1);
            end
            push("tone", rnd(GAIN * 10000.0), 0, rnd(GAIN * 100.0));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
